// File: rtl/sha_msg_arb_if.sv
`timescale 1ns/1ps
// sha_msg_arb_if
// Byte-stream bundle between the requesters, the arbiter and the SHA padder.
//   req_valid/req_data/req_last : per-requester byte stream (byte i in [8i+7:8i])
//   req_ready                   : per-requester byte accept
//   pad_valid/pad_data/pad_last : arbitrated byte stream towards the padder
//   pad_ready                   : padder accept
// Modports:
//   slave  : arbiter view (consumes requester bytes, produces padder bytes)
//   master : environment view (requesters plus padder)
interface sha_msg_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 pad_valid;
    logic                 pad_ready;
    logic [7:0]           pad_data;
    logic                 pad_last;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready,
        output pad_valid,
        input  pad_ready,
        output pad_data,
        output pad_last
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready,
        input  pad_valid,
        output pad_ready,
        input  pad_data,
        input  pad_last
    );
endinterface

// File: rtl/sha_msg_arb.sv
`timescale 1ns/1ps
// sha_msg_arb
// Message-granular arbiter sharing one SHA byte-stream padder among NUM_REQ
// requesters. One requester is granted per message and the grant stays locked
// until that requester's last byte is accepted by the padder. The owner of each
// granted message is pushed into a tag FIFO so the downstream digest can be
// routed back to the requester that produced it.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : requester byte streams in, padder byte stream out
//   grant_vld      : a message is currently locked
//   grant_id       : locked requester
//   dig_done       : one-cycle pulse, digest of the oldest in-flight message done
//   dig_owner      : owner of the oldest in-flight message (FIFO head)
//   dig_owner_vld  : tag FIFO not empty
//   tag_full       : tag FIFO full (blocks new grants)
//   err_underflow  : sticky, dig_done seen while the tag FIFO was empty
//
// Build option:
//   SHA_ARB_FIXED_PRIO_EN defined   : fixed priority, lowest asserted index wins
//   SHA_ARB_FIXED_PRIO_EN undefined : round-robin starting at rr_ptr
module sha_msg_arb #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sha_msg_arb_if.slave    bus,
    output logic            grant_vld,
    output logic [ID_W-1:0] grant_id,
    input  logic            dig_done,
    output logic [ID_W-1:0] dig_owner,
    output logic            dig_owner_vld,
    output logic            tag_full,
    output logic            err_underflow
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nx;
    logic [ID_W-1:0] grant_id_r;
    logic [ID_W-1:0] grant_id_nx;
`ifndef SHA_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] rr_ptr_nx;
`endif

    // Arbitration
    logic [ID_W-1:0] winner_s;
    logic            winner_vld_s;
    int              dist_s;
    int              best_s;

    // Selected requester's stream
    logic            sel_valid_s;
    logic            sel_last_s;
    logic [7:0]      sel_data_s;
    logic            msg_end_s;

    // Tag FIFO
    logic [ID_W-1:0]  tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;
    logic             err_r;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == CNT_FULL);
    // A push can only come from a grant, which is never issued while full.
    assign pop_s   = dig_done & ~empty_s;

    // Winner selection: the smallest scan distance among asserted requesters.
    // Round-robin measures distance from rr_ptr with wrap; fixed priority uses
    // the index itself, so the lowest asserted index wins.
    always_comb begin
        winner_s     = {ID_W{1'b0}};
        winner_vld_s = 1'b0;
        best_s       = NUM_REQ;
        dist_s       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SHA_ARB_FIXED_PRIO_EN
            dist_s = i;
`else
            dist_s = (i + NUM_REQ - int'(rr_ptr_r)) % NUM_REQ;
`endif
            if (bus.req_valid[i] && (dist_s < best_s)) begin
                best_s       = dist_s;
                winner_s     = ID_W'(i);
                winner_vld_s = 1'b1;
            end else begin
                winner_vld_s = winner_vld_s;
            end
        end
    end

    // Select the locked requester's byte stream (one-hot AND-OR mux).
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_valid_s = sel_valid_s | ((grant_id_r == ID_W'(i)) & bus.req_valid[i]);
            sel_last_s  = sel_last_s  | ((grant_id_r == ID_W'(i)) & bus.req_last[i]);
            sel_data_s  = sel_data_s  | ((grant_id_r == ID_W'(i)) ? bus.req_data[8*i +: 8] : 8'h00);
        end
    end

    // Last byte of the locked message accepted by the padder.
    assign msg_end_s = (state_r == ST_LOCK) & sel_valid_s & bus.pad_ready & sel_last_s;

    // Next-state and passthrough outputs.
    always_comb begin
        state_nx      = state_r;
        grant_id_nx   = grant_id_r;
`ifndef SHA_ARB_FIXED_PRIO_EN
        rr_ptr_nx     = rr_ptr_r;
`endif
        push_s        = 1'b0;
        bus.pad_valid = 1'b0;
        bus.pad_data  = 8'h00;
        bus.pad_last  = 1'b0;
        bus.req_ready = {NUM_REQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (winner_vld_s && !full_s) begin
                    state_nx    = ST_LOCK;
                    grant_id_nx = winner_s;
                    push_s      = 1'b1;
                end else begin
                    state_nx    = ST_IDLE;
                end
            end
            ST_LOCK: begin
                bus.pad_valid = sel_valid_s;
                bus.pad_data  = sel_data_s;
                bus.pad_last  = sel_last_s;
                for (int i = 0; i < NUM_REQ; i++) begin
                    bus.req_ready[i] = (grant_id_r == ID_W'(i)) ? bus.pad_ready : 1'b0;
                end
                if (msg_end_s) begin
                    state_nx = ST_IDLE;
`ifndef SHA_ARB_FIXED_PRIO_EN
                    // Next scan starts just after the requester that finished.
                    rr_ptr_nx = (grant_id_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                                   : grant_id_r + ID_W'(1);
`endif
                end else begin
                    state_nx = ST_LOCK;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            grant_id_r <= {ID_W{1'b0}};
`ifndef SHA_ARB_FIXED_PRIO_EN
            rr_ptr_r   <= {ID_W{1'b0}};
`endif
        end else begin
            state_r    <= state_nx;
            grant_id_r <= grant_id_nx;
`ifndef SHA_ARB_FIXED_PRIO_EN
            rr_ptr_r   <= rr_ptr_nx;
`endif
        end
    end

    // Owner-tag FIFO: push on LOCK entry, pop on dig_done; both may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= {ID_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= grant_id_nx;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r            <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (dig_done && empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign grant_vld     = (state_r == ST_LOCK);
    assign grant_id      = grant_id_r;
    assign dig_owner     = tag_mem_r[rd_ptr_r];
    assign dig_owner_vld = ~empty_s;
    assign tag_full      = full_s;
    assign err_underflow = err_r;

endmodule

// File: doc/sha_msg_arb.md
Name: sha_msg_arb

Overview:
- Message-granular arbiter that shares one SHA byte-stream padder among NUM_REQ independent requesters.
- Grants one requester per message and locks the grant until that requester's last byte is accepted.
- Records the owner of each message in a tag FIFO, so the digest produced downstream can be routed back to the correct requester.
- Sits between the requester byte interfaces and the padder's in_valid/in_ready/in_data/in_last port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ
TAG_DEPTH, 4, owner-tag FIFO depth, i.e. messages in flight downstream (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  per-requester last-byte marker
req_ready  out  NUM_REQ  per-requester byte accept
pad_valid  out  1  byte valid to padder
pad_ready  in  1  padder ready
pad_data  out  8  byte to padder
pad_last  out  1  last byte to padder
grant_vld  out  1  a message is currently locked
grant_id  out  ID_W  locked requester
dig_done  in  1  one-cycle pulse: downstream digest for the oldest in-flight message is complete
dig_owner  out  ID_W  owner of the oldest in-flight message (FIFO head)
dig_owner_vld  out  1  FIFO not empty
tag_full  out  1  FIFO full
err_underflow  out  1  sticky: dig_done seen while FIFO empty

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; FIFO empty; err_underflow=0. Reset asserted mid-message aborts the message immediately, with no partial tag retained.
- States: IDLE, LOCK.
- IDLE:
  - req_ready=0 and pad_valid=0.
  - If any req_valid and !tag_full, select the winner by round-robin: the first asserted index at or after rr_ptr, with wrap.
  - Next cycle: state=LOCK, grant_id=winner, grant_vld=1, winner's ID pushed into the FIFO.
  - Grant latency is one cycle from req_valid.
- LOCK:
  - Combinational passthrough: pad_valid=req_valid[g], pad_data=req_data[g], pad_last=req_last[g], req_ready[g]=pad_ready.
  - All other req_ready=0.
- LOCK exit: on a handshake (pad_valid & pad_ready) with pad_last=1:
  - Next state IDLE; grant_vld=0.
  - rr_ptr=(g+1) mod NUM_REQ.
  - Exactly one bubble cycle occurs between messages.
- Deassertion of req_valid[g] in LOCK does not release the grant, which stays locked indefinitely.
- Zero-length messages are unsupported: each message is at least one byte.
- tag_full in IDLE blocks new grants. It never affects a message already locked.
- FIFO behaviour:
  - Push at the LOCK entry edge. Pop on dig_done when non-empty.
  - Push and pop in the same cycle: both occur and the count is unchanged. This is legal even when full, but a grant is never issued while full, so the case only arises with pop.
  - Pointers wrap mod TAG_DEPTH.
  - dig_done when empty: no pop; err_underflow set to 1 until reset.
- dig_owner and dig_owner_vld are combinational from the FIFO head and count.
- req_valid/req_last on unselected requesters are ignored. Requesters must hold data stable while valid&!ready.

Optional Feature:
SHA_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest asserted index wins; rr_ptr is neither updated nor used.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Single requester 1: 3-byte message 61 62 63 with last on 63, pad_ready=1 → grant_vld rises 1 cycle after req_valid, grant_id=1; pad_data sequence 61,62,63 with pad_last on 63; dig_owner_vld=1, dig_owner=1; dig_done → dig_owner_vld=0.
- Contention: all 4 requesters hold 2-byte messages, rr_ptr=0 → grant order 0,1,2,3 with one idle cycle between messages; FIFO holds 0,1,2,3; after 4 dig_done pulses dig_owner reads 0,1,2,3.
- Backpressure: pad_ready toggled 1010… during a 5-byte message → req_ready[g] mirrors pad_ready, no byte duplicated or dropped; other req_ready stay 0.
- FIFO full (TAG_DEPTH=4): 4 messages completed, no dig_done, requester 2 valid → no grant, tag_full=1; single dig_done → grant to requester 2 next cycle.
- Simultaneous: LOCK entry coincides with dig_done on a 3-deep FIFO → count stays 3 and head advances. Separately, dig_done on an empty FIFO → err_underflow=1 and held.
- Reset mid-message: rst_n low after 2 of 4 bytes → all outputs 0 asynchronously; after release, requester 3 is granted first on valid (rr_ptr=0 scan). With SHA_ARB_FIXED_PRIO_EN, requesters 1 and 3 valid together → grant to 1 every time.
